// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types, widths and the round-robin pick helper for the AR arbiter
package axi_arb_pkg;

    localparam int AR_W = 45;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_payload_t;

    typedef enum logic {IDLE, PUSH} arb_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Scans offsets from the highest down so the smallest offset from ptr wins last.
    // Callers must keep ptr < n; n is limited to 2..8.
    function automatic rr_pick_t rr_pick(input logic [7:0] valid_mask, input logic [2:0] ptr,
                                         input logic [3:0] n);
        rr_pick_t r;
        logic [3:0] s;
        r = '0;
        for (int o = 7; o >= 0; o--) begin
            s = {1'b0, ptr} + 4'(o);
            if (s >= n) s = s - n;
            if (4'(o) < n && valid_mask[s[2:0]]) begin
                r.found = 1'b1;
                r.idx   = s[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin scan starting at ptr
//   valid : per-master eligibility mask
//   ptr   : highest-priority index this cycle
//   found : some master is eligible
//   idx   : winning master index
module rr_picker
    import axi_arb_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    rr_pick_t p;

    always_comb begin
        p     = rr_pick(8'(valid), 3'(ptr), 4'(NUM_M));
        found = p.found;
        idx   = IDX_W'(p.idx);
    end

endmodule

// File: rtl/ar_arbiter.sv
// ar_arbiter: round-robin arbiter feeding the AR clock-crossing FIFO write port
//   clk, rst_n     : master-domain clock, async active-low reset
//   m_arvalid/ready: per-master handshake (ready is one-hot or zero)
//   m_ardata       : per-master payload, master i at [i*AR_W +: AR_W]
//   fifo_push/data/src/full : FIFO write side and owner of the held payload
//   rd_done, rd_done_src    : read completion returning an outstanding credit
//   err_underflow  : sticky, completion seen for a master with nothing outstanding
//   AR_ARB_PERF_EN : adds perf_grant_cnt (16b per master) and perf_stall_cnt
module ar_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M   = 3,
    parameter int MAX_OUT = 4,
    parameter int AR_W    = axi_arb_pkg::AR_W,
    parameter int IDX_W   = $clog2(NUM_M)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_M-1:0]      m_arvalid,
    output logic [NUM_M-1:0]      m_arready,
    input  logic [NUM_M*AR_W-1:0] m_ardata,
    output logic                  fifo_push,
    output logic [AR_W-1:0]       fifo_data,
    input  logic                  fifo_full,
    output logic [IDX_W-1:0]      fifo_src,
    input  logic                  rd_done,
    input  logic [IDX_W-1:0]      rd_done_src,
    output logic                  err_underflow
`ifdef AR_ARB_PERF_EN
    ,
    output logic [NUM_M*16-1:0]   perf_grant_cnt,
    output logic [15:0]           perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    arb_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [AR_W-1:0]               data_q, data_d;
    logic [IDX_W-1:0]              src_q, src_d;
    logic [NUM_M-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic [NUM_M-1:0]              eligible, inc, dec;
    logic                          found;
    logic [IDX_W-1:0]              win;

    always_comb begin
        eligible = '0;
        inc      = '0;
        dec      = '0;
        for (int i = 0; i < NUM_M; i++) begin
            eligible[i] = m_arvalid[i] && cnt_q[i] < CNT_W'(MAX_OUT);
            inc[i]      = fifo_push && src_q == IDX_W'(i);
            dec[i]      = rd_done && rd_done_src == IDX_W'(i);
        end
    end

    rr_picker #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
        .valid(eligible),
        .ptr  (rr_ptr_q),
        .found(found),
        .idx  (win)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        data_d    = data_q;
        src_d     = src_q;
        m_arready = '0;
        fifo_push = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                m_arready[win] = 1'b1;
                data_d         = m_ardata[win*AR_W +: AR_W];
                src_d          = win;
                rr_ptr_d       = (win == IDX_W'(NUM_M - 1)) ? '0 : win + 1'b1;
                state_d        = PUSH;
            end
        end else begin
            fifo_push = ~fifo_full;
            if (!fifo_full) state_d = IDLE;
        end
    end

    // A push and a completion for the same master cancel; underflow only on a net decrement at zero.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int i = 0; i < NUM_M; i++) begin
            if (dec[i] && !inc[i] && cnt_q[i] == '0) err_d = 1'b1;
            cnt_d[i] = (inc[i] && !dec[i]) ? cnt_q[i] + 1'b1 :
                       (dec[i] && !inc[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            data_q   <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign fifo_data     = data_q;
    assign fifo_src      = src_q;
    assign err_underflow = err_q;

`ifdef AR_ARB_PERF_EN
    logic [NUM_M-1:0][15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_M; i++)
            if (inc[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
        stall_cnt_d = (state_q == PUSH && fifo_full && stall_cnt_q != 16'hFFFF) ?
                      stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ar_arbiter.sv
// tb_ar_arbiter: randomized and directed checks of ar_arbiter against a transaction-level model
module tb_ar_arbiter;

    localparam int N  = 3;
    localparam int MO = 4;
    localparam int W  = 45;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   m_arvalid = '0;
    logic [N-1:0]   m_arready;
    logic [N*W-1:0] m_ardata = '0;
    logic           fifo_push;
    logic [W-1:0]   fifo_data;
    logic           fifo_full = 1'b0;
    logic [IW-1:0]  fifo_src;
    logic           rd_done = 1'b0;
    logic [IW-1:0]  rd_done_src = '0;
    logic           err_underflow;
`ifdef AR_ARB_PERF_EN
    logic [N*16-1:0] perf_grant_cnt;
    logic [15:0]     perf_stall_cnt;
`endif

    ar_arbiter #(.NUM_M(N), .MAX_OUT(MO), .AR_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_ardata     (m_ardata),
        .fifo_push    (fifo_push),
        .fifo_data    (fifo_data),
        .fifo_full    (fifo_full),
        .fifo_src     (fifo_src),
        .rd_done      (rd_done),
        .rd_done_src  (rd_done_src),
        .err_underflow(err_underflow)
`ifdef AR_ARB_PERF_EN
        ,
        .perf_grant_cnt(perf_grant_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Transaction-level model: a one-deep holding slot, priority pointer, credit counts
    int           ptr = 0;
    int           outs[N];
    bit           held = 0;
    logic [W-1:0] hdata = '0;
    int           hsrc = 0;
    logic         err = 1'b0;
    logic [W-1:0] d1_fix = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        ptr = 0; held = 0; hdata = '0; hsrc = 0; err = 1'b0;
        for (int i = 0; i < N; i++) outs[i] = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model for the next posedge
    task automatic cycle(input logic [N-1:0] v, input logic full, input logic done, input int dsrc);
        int win, inc_src, nv;
        logic [N-1:0] exp_rdy;
        m_arvalid   = v;
        fifo_full   = full;
        rd_done     = done;
        rd_done_src = IW'(dsrc);
        for (int i = 0; i < N; i++) m_ardata[i*W +: W] = W'({$urandom, $urandom});
        if (d1_fix != '0) m_ardata[W +: W] = d1_fix;
        @(negedge clk);
        win = -1;
        if (!held)
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (win < 0 && v[i] && outs[i] < MO) win = i;
            end
        exp_rdy = (win >= 0) ? N'(1 << win) : '0;
        chk("arready", 64'(m_arready), 64'(exp_rdy));
        chk("push", 64'(fifo_push), 64'(held && !full));
        chk("data", 64'(fifo_data), 64'(hdata));
        chk("src", 64'(fifo_src), 64'(hsrc));
        chk("err", 64'(err_underflow), 64'(err));
        inc_src = (held && !full) ? hsrc : -1;
        if (held && !full) held = 0;
        else if (win >= 0) begin
            held  = 1;
            hdata = m_ardata[win*W +: W];
            hsrc  = win;
            ptr   = (win + 1) % N;
        end
        for (int j = 0; j < N; j++) begin
            int d;
            d  = (done && dsrc == j) ? 1 : 0;
            if (d == 1 && inc_src != j && outs[j] == 0) err = 1'b1;
            nv = outs[j] + ((inc_src == j) ? 1 : 0) - d;
            outs[j] = (nv < 0) ? 0 : nv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cycle('0, 1'b0, 1'b0, 0);
        for (int j = 0; j < N; j++)
            while (outs[j] > 0) cycle('0, 1'b0, 1'b1, j);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_arready", 64'(m_arready), 64'(0));
        chk("rst_push", 64'(fifo_push), 64'(0));
        chk("rst_data", 64'(fifo_data), 64'(0));
        chk("rst_src", 64'(fifo_src), 64'(0));
        chk("rst_err", 64'(err_underflow), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single master with a fixed payload
        d1_fix = 45'h0_1234_5678_0_2_1;
        cycle(3'b010, 1'b0, 1'b0, 0);
        cycle(3'b000, 1'b0, 1'b0, 0);
        chk("single_cnt", 64'(outs[1]), 64'(1));
        d1_fix = '0;
        cycle(3'b000, 1'b0, 1'b1, 1);

        // Round robin, completion coinciding with each push
        repeat (6) begin
            cycle(3'b111, 1'b0, 1'b0, 0);
            cycle(3'b111, 1'b0, 1'b1, hsrc);
        end

        // Outstanding limit on master 0, then one credit returned
        repeat (10) cycle(3'b001, 1'b0, 1'b0, 0);
        chk("limit_cnt", 64'(outs[0]), 64'(MO));
        cycle(3'b001, 1'b0, 1'b1, 0);
        cycle(3'b001, 1'b0, 1'b0, 0);
        drain();

        // Backpressure held for five cycles
        cycle(3'b111, 1'b0, 1'b0, 0);
        repeat (5) cycle(3'b111, 1'b1, 1'b0, 0);
        cycle(3'b111, 1'b0, 1'b0, 0);
        drain();

        // Underflow is sticky; out-of-range completion ignored
        cycle(3'b000, 1'b0, 1'b1, 3);
        cycle(3'b000, 1'b0, 1'b1, 1);
        cycle(3'b000, 1'b0, 1'b0, 0);
        cycle(3'b000, 1'b0, 1'b0, 0);

        // Random traffic
        repeat (400) begin
            int j;
            logic d;
            j = int'($urandom_range(0, 3));
            d = ($urandom_range(0, 1) == 1) && (j == 3 || outs[j] > 0);
            cycle(N'($urandom), $urandom_range(0, 3) == 0, d, j);
        end

        // Asynchronous reset while holding a request against a full FIFO
        drain();
        cycle(3'b111, 1'b0, 1'b0, 0);
        cycle(3'b111, 1'b1, 1'b0, 0);
        m_arvalid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_arready", 64'(m_arready), 64'(0));
        chk("arst_push", 64'(fifo_push), 64'(0));
        chk("arst_data", 64'(fifo_data), 64'(0));
        chk("arst_src", 64'(fifo_src), 64'(0));
        chk("arst_err", 64'(err_underflow), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(3'b111, 1'b0, 1'b0, 0);
        chk("post_rst_grant", 64'(hsrc), 64'(0));
        cycle(3'b111, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
